// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter:
// FSM encoding and Wishbone bus widths.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TOUT = 2'd2
    } arb_state_t;

    localparam int WB_DW = 32;
    localparam int WB_AW = 32;
    localparam int WB_SW = 4;

    // Width of an index into n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: the first requester found scanning
// upward from last_grant+1 (modulo N) wins.
module rr_priority_pick
    import wb_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  winner,
    output logic          valid
);

    logic [IW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(last_grant) + i) % N);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: one owner per bus cycle, with a
// watchdog that answers err to the owner when the slave never responds.
//
// state | meaning
// IDLE  | no owner; arbitrate among masters with cyc & stb
// BUSY  | granted master drives the slave port until it drops cyc
// TOUT  | watchdog fired; one cycle of err to the owner, slave port quiet
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic [NUM_MASTERS-1:0]       m_cyc_i,
    input  logic [NUM_MASTERS-1:0]       m_stb_i,
    input  logic [NUM_MASTERS-1:0]       m_we_i,
    input  logic [4*NUM_MASTERS-1:0]     m_sel_i,
    input  logic [32*NUM_MASTERS-1:0]    m_adr_i,
    input  logic [32*NUM_MASTERS-1:0]    m_dat_i,
    output logic [31:0]                  m_dat_o,
    output logic [NUM_MASTERS-1:0]       m_ack_o,
    output logic [NUM_MASTERS-1:0]       m_err_o,
    output logic                         s_cyc_o,
    output logic                         s_stb_o,
    output logic                         s_we_o,
    output logic [3:0]                   s_sel_o,
    output logic [31:0]                  s_adr_o,
    output logic [31:0]                  s_dat_o,
    input  logic [31:0]                  s_dat_i,
    input  logic                         s_ack_i,
    input  logic                         s_err_i,
    output logic [NUM_MASTERS-1:0]       grant_o,
    output logic                         timeout_o
);

    localparam int IW = idx_width(NUM_MASTERS);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic                   pick_valid;
    logic [IW-1:0]          last_grant_q;
    logic [IW-1:0]          pick_idx;
    logic [IW-1:0]          gnt_idx;
    logic [CNT_W-1:0]       wdog_q;
    logic                   own_cyc;
    logic                   stall;
    logic                   wdog_hit;

    assign req = m_cyc_i & m_stb_i;

    rr_priority_pick #(
        .N (NUM_MASTERS),
        .IW(IW)
    ) u_pick (
        .req       (req),
        .last_grant(last_grant_q),
        .winner    (pick_onehot),
        .valid     (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        gnt_idx  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (pick_onehot[k]) pick_idx = IW'(k);
            if (grant_q[k])     gnt_idx  = IW'(k);
        end
    end

    assign own_cyc  = m_cyc_i[gnt_idx];
    // s_stb_o is already zero outside BUSY, so stall only counts owned strobes.
    assign stall    = s_stb_o & ~s_ack_i & ~s_err_i;
    assign wdog_hit = stall && (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = BUSY;
            BUSY: begin
                if (!own_cyc)      state_d = IDLE;
                else if (wdog_hit) state_d = TOUT;
            end
            TOUT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_ack_o   = '0;
        m_err_o   = '0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        timeout_o = 1'b0;
        case (state_q)
            BUSY: begin
                s_cyc_o          = m_cyc_i[gnt_idx];
                s_stb_o          = m_stb_i[gnt_idx];
                s_we_o           = m_we_i[gnt_idx];
                s_sel_o          = m_sel_i[int'(gnt_idx)*WB_SW +: WB_SW];
                s_adr_o          = m_adr_i[int'(gnt_idx)*WB_AW +: WB_AW];
                s_dat_o          = m_dat_i[int'(gnt_idx)*WB_DW +: WB_DW];
                m_ack_o[gnt_idx] = s_ack_i;
                m_err_o[gnt_idx] = s_err_i;
            end
            TOUT: begin
                m_err_o[gnt_idx] = 1'b1;
                timeout_o        = 1'b1;
            end
            default: ;
        endcase
    end

    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            grant_q      <= '0;
            last_grant_q <= IW'(NUM_MASTERS - 1);
            wdog_q       <= '0;
        end else begin
            if (state_q == IDLE && pick_valid) begin
                grant_q      <= pick_onehot;
                last_grant_q <= pick_idx;
            end else if (state_d == IDLE) begin
                grant_q <= '0;
            end
            wdog_q <= (state_q == BUSY && stall) ? wdog_q + 1'b1 : '0;
        end
    end

endmodule
